pwm_duty_ramp: RTL and testbench

Per-channel duty conditioner between the MCU PWM register bank and the PWM waveform generator. It takes the raw 24-bit period and target duty written by the MCU and slews the duty delivered to the generator by a programmable step once per PWM period. Period and duty reach the generator only at period boundaries, so it never sees a half-written value. This prevents current spikes on motor outputs when the MCU changes duty abruptly.

---
 rtl/pwm_duty_ramp.sv | 143 ++++++++++++++
 tb/tb_pwm_duty_ramp.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp.sv
// Per-channel PWM duty slew limiter: period/duty reach the generator only at period boundaries.
// Optional done interrupt is enabled with `define PWM_RAMP_DONE_IRQ_EN.
module pwm_duty_ramp #(
  parameter int unsigned      WIDTH    = 24,
  parameter logic [WIDTH-1:0] DEF_STEP = WIDTH'(24'h000100)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             ramp_en,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] duty_target,
  input  logic [WIDTH-1:0] step_cfg,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] duty_out,
  output logic             period_tick,
  output logic             ramping
`ifdef PWM_RAMP_DONE_IRQ_EN
  ,
  output logic             done_irq
`endif
);

  localparam int unsigned SUM_W = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  state_e           dir;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] down_gap;
  logic [SUM_W-1:0] up_sum;
  logic             tick;

  // Effective target, step and the last-cycle-of-period strobe
  always_comb begin
    tgt  = '0;
    step = step_cfg;
    if (enable) begin
      tgt = (duty_target < period_in) ? duty_target : period_in;
    end
    if (step_cfg == '0) begin
      step = DEF_STEP;
    end
    tick = (period_q != '0) && (cnt_q == period_q - WIDTH'(1));
  end

  // Next-state and datapath update; inputs only take effect on a tick
  always_comb begin
    period_d = period_q;
    duty_d   = duty_q;
    cnt_d    = cnt_q + WIDTH'(1);
    dir      = IDLE;
    state_d  = IDLE;
    up_sum   = SUM_W'({1'b0, duty_q}) + SUM_W'({1'b0, step});
    down_gap = duty_q - tgt;

    if (duty_q < tgt) begin
      dir = UP;
    end else if (duty_q > tgt) begin
      dir = DOWN;
    end

    // Wrap on the last count, and also if a shrunken period left cnt past the end
    if ((period_q == '0) || (cnt_q >= period_q - WIDTH'(1))) begin
      cnt_d = '0;
    end

    if (tick) begin
      period_d = period_in;
      if (!ramp_en) begin
        duty_d = tgt;
      end else begin
        case (dir)
          UP:      duty_d = (up_sum >= SUM_W'({1'b0, tgt})) ? tgt : up_sum[WIDTH-1:0];
          DOWN:    duty_d = (down_gap <= step) ? tgt : duty_q - step;
          default: duty_d = duty_q;
        endcase
      end
    end else if ((period_q == '0) && (period_in != '0)) begin
      period_d = period_in;
    end

    if (duty_d < tgt) begin
      state_d = UP;
    end else if (duty_d > tgt) begin
      state_d = DOWN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q <= '0;
      duty_q   <= '0;
      cnt_q    <= '0;
    end else begin
      period_q <= period_d;
      duty_q   <= duty_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef PWM_RAMP_DONE_IRQ_EN
  logic done_q, done_d;

  // Pulse only when a tick actually moved duty onto the target
  always_comb begin
    done_d = tick && (dir != IDLE) && (duty_d == tgt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign done_irq = done_q;
`endif

  assign period_out  = period_q;
  assign duty_out    = duty_q;
  assign period_tick = tick;
  assign ramping     = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Self-checking bench for pwm_duty_ramp: directed scenarios plus randomized traffic
// compared every cycle against a period-level behavioural model.
module tb_pwm_duty_ramp;

  localparam int unsigned W = 24;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         ramp_en;
  logic [W-1:0] period_in;
  logic [W-1:0] duty_target;
  logic [W-1:0] step_cfg;
  logic [W-1:0] period_out;
  logic [W-1:0] duty_out;
  logic         period_tick;
  logic         ramping;
  logic         done_irq;

  int vectors  = 0;
  int errs     = 0;
  int cyc      = 0;
  int done_cnt = 0;
  bit chk_on   = 0;

  always #5 clk = ~clk;

  pwm_duty_ramp #(.WIDTH(W), .DEF_STEP(24'h000100)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .ramp_en(ramp_en),
    .period_in(period_in),
    .duty_target(duty_target),
    .step_cfg(step_cfg),
    .period_out(period_out),
    .duty_out(duty_out),
    .period_tick(period_tick),
    .ramping(ramping)
`ifdef PWM_RAMP_DONE_IRQ_EN
    ,
    .done_irq(done_irq)
`endif
  );

`ifndef PWM_RAMP_DONE_IRQ_EN
  assign done_irq = 1'b0;
`endif

  // Reference model: period length, current duty and position within the period
  longint m_per, m_duty, m_cnt;
  bit     m_ramp, m_done;
  longint m_tgt, m_s, m_nd;
  bit     m_tick;

  function automatic longint lmin(longint a, longint b);
    return (a < b) ? a : b;
  endfunction

  function automatic longint lmax(longint a, longint b);
    return (a > b) ? a : b;
  endfunction

  function automatic longint slew(longint d, longint t, longint s, bit ramp);
    if (!ramp) return t;
    if (d < t) return lmin(d + s, t);
    if (d > t) return lmax(d - s, t);
    return d;
  endfunction

  assign m_tick = (m_per != 0) && (m_cnt == m_per - 1);
  assign m_tgt  = enable ? lmin(longint'(duty_target), longint'(period_in)) : 0;
  assign m_s    = (step_cfg == 0) ? 256 : longint'(step_cfg);
  assign m_nd   = m_tick ? slew(m_duty, m_tgt, m_s, ramp_en) : m_duty;

  initial begin
    m_per = 0; m_duty = 0; m_cnt = 0; m_ramp = 0; m_done = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_per = 0; m_duty = 0; m_cnt = 0; m_ramp = 0; m_done = 0;
      end else begin
        cyc    = cyc + 1;
        m_done = m_tick && (m_duty != m_tgt) && (m_nd == m_tgt);
        m_ramp = (m_nd != m_tgt);
        m_cnt  = (m_tick || m_per == 0) ? 0 : m_cnt + 1;
        if (m_tick || (m_per == 0 && period_in != 0)) m_per = longint'(period_in);
        m_duty = m_nd;
      end
    end
  end

  // Continuous scoreboard against the model, sampled mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (done_irq === 1'b1) done_cnt++;
      if (chk_on) begin
        vectors++;
        if (period_out !== W'(m_per)) begin
          errs++; $display("FAIL mon_period t=%0t got %0d exp %0d", $time, period_out, m_per);
        end
        vectors++;
        if (duty_out !== W'(m_duty)) begin
          errs++; $display("FAIL mon_duty t=%0t got %0d exp %0d", $time, duty_out, m_duty);
        end
        vectors++;
        if (period_tick !== m_tick) begin
          errs++; $display("FAIL mon_tick t=%0t got %b exp %b", $time, period_tick, m_tick);
        end
        vectors++;
        if (ramping !== m_ramp) begin
          errs++; $display("FAIL mon_ramping t=%0t got %b exp %b", $time, ramping, m_ramp);
        end
`ifdef PWM_RAMP_DONE_IRQ_EN
        vectors++;
        if (done_irq !== m_done) begin
          errs++; $display("FAIL mon_done_irq t=%0t got %b exp %b", $time, done_irq, m_done);
        end
`endif
      end
    end
  end

  task automatic wait_tick(output bit ok);
    int k;
    k  = 0;
    ok = 0;
    while (k < 3000) begin
      if (period_tick === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; ramp_en = 1'b0;
    period_in = '0; duty_target = '0; step_cfg = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({period_out, duty_out, period_tick, ramping} !== '0) begin
      errs++; $display("FAIL reset_outputs got p=%0d d=%0d t=%b r=%b exp all 0",
                       period_out, duty_out, period_tick, ramping);
    end
    chk_on = 1;
    reset  = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (period_out !== '0 || period_tick !== 1'b0) begin
      errs++; $display("FAIL reset_idle_period got p=%0d t=%b exp 0 0", period_out, period_tick);
    end
  endtask

  task automatic test_ramp_up;
    int exp_d[3] = '{20, 40, 50};
    int last, d0;
    bit ok;
    last = 0;
    d0   = done_cnt;
    period_in = W'(100); duty_target = W'(50); step_cfg = W'(20);
    ramp_en = 1'b1; enable = 1'b1;
    @(negedge clk);
    vectors++;
    if (period_out !== W'(100)) begin
      errs++; $display("FAIL up_bootstrap got %0d exp 100", period_out);
    end
    for (int i = 0; i < 3; i++) begin
      wait_tick(ok);
      vectors++;
      if (!ok) begin
        errs++; $display("FAIL up_tick_timeout got none exp tick %0d", i);
        return;
      end
      if (i > 0) begin
        vectors++;
        if (cyc - last != 100) begin
          errs++; $display("FAIL up_tick_spacing got %0d exp 100", cyc - last);
        end
      end
      last = cyc;
      @(negedge clk);
      vectors++;
      if (duty_out !== W'(exp_d[i])) begin
        errs++; $display("FAIL up_duty got %0d exp %0d", duty_out, exp_d[i]);
      end
      vectors++;
      if (ramping !== (i != 2)) begin
        errs++; $display("FAIL up_ramping got %b exp %b", ramping, i != 2);
      end
    end
`ifdef PWM_RAMP_DONE_IRQ_EN
    @(negedge clk);
    vectors++;
    if (done_cnt - d0 != 1) begin
      errs++; $display("FAIL up_done_count got %0d exp 1", done_cnt - d0);
    end
`endif
  endtask

  task automatic test_ramp_down;
    int exp_d[3] = '{30, 10, 5};
    bit ok;
    duty_target = W'(5); step_cfg = W'(20);
    for (int i = 0; i < 3; i++) begin
      wait_tick(ok);
      vectors++;
      if (!ok) begin
        errs++; $display("FAIL down_tick_timeout got none exp tick %0d", i);
        return;
      end
      @(negedge clk);
      vectors++;
      if (duty_out !== W'(exp_d[i])) begin
        errs++; $display("FAIL down_duty got %0d exp %0d", duty_out, exp_d[i]);
      end
    end
    wait_tick(ok);
    @(negedge clk);
    vectors++;
    if (duty_out !== W'(5)) begin
      errs++; $display("FAIL down_clamp got %0d exp 5", duty_out);
    end
  endtask

  task automatic test_target_above;
    bit ok;
    ramp_en = 1'b0; duty_target = W'(300);
    wait_tick(ok);
    @(negedge clk);
    vectors++;
    if (!ok || duty_out !== W'(100)) begin
      errs++; $display("FAIL above_period got %0d ok=%b exp 100", duty_out, ok);
    end
  endtask

  task automatic test_disable;
    bit ok;
    duty_target = W'(40); period_in = W'(1000);
    wait_tick(ok);
    @(negedge clk);
    vectors++;
    if (!ok || duty_out !== W'(40) || period_out !== W'(1000)) begin
      errs++; $display("FAIL dis_setup got d=%0d p=%0d exp 40 1000", duty_out, period_out);
    end
    ramp_en = 1'b1; enable = 1'b0; step_cfg = '0;
    @(negedge clk);
    vectors++;
    if (ramping !== 1'b1) begin
      errs++; $display("FAIL dis_ramping_set got %b exp 1", ramping);
    end
    wait_tick(ok);
    @(negedge clk);
    vectors++;
    if (!ok || duty_out !== '0 || ramping !== 1'b0) begin
      errs++; $display("FAIL dis_result got d=%0d r=%b exp 0 0", duty_out, ramping);
    end
  endtask

  task automatic test_shrink;
    int last;
    bit ok;
    enable = 1'b1; duty_target = W'(500);
    wait_tick(ok);
    last = cyc;
    @(negedge clk);
    repeat (500) @(negedge clk);
    period_in = W'(10);
    repeat (100) @(negedge clk);
    vectors++;
    if (period_out !== W'(1000) || duty_out !== W'(256)) begin
      errs++; $display("FAIL shrink_hold got p=%0d d=%0d exp 1000 256", period_out, duty_out);
    end
    wait_tick(ok);
    vectors++;
    if (!ok || cyc - last != 1000) begin
      errs++; $display("FAIL shrink_long_tick got %0d exp 1000", cyc - last);
    end
    last = cyc;
    @(negedge clk);
    vectors++;
    if (period_out !== W'(10) || duty_out !== W'(10)) begin
      errs++; $display("FAIL shrink_load got p=%0d d=%0d exp 10 10", period_out, duty_out);
    end
    for (int i = 0; i < 3; i++) begin
      wait_tick(ok);
      vectors++;
      if (!ok || cyc - last != 10) begin
        errs++; $display("FAIL shrink_spacing got %0d exp 10", cyc - last);
      end
      last = cyc;
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) period_in = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(1, 20));
      if ($urandom_range(0, 5) == 0) duty_target = W'($urandom_range(0, 40));
      if ($urandom_range(0, 9) == 0) step_cfg = W'($urandom_range(0, 12));
      if ($urandom_range(0, 19) == 0) ramp_en = ~ramp_en;
      if ($urandom_range(0, 29) == 0) enable = ~enable;
    end
  endtask

  task automatic test_async_reset;
    bit ok;
    period_in = W'(50); duty_target = W'(40); step_cfg = W'(5);
    ramp_en = 1'b1; enable = 1'b1;
    wait_tick(ok);
    @(negedge clk);
    wait_tick(ok);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (duty_out !== '0 || period_out !== '0 || period_tick !== 1'b0 || ramping !== 1'b0) begin
      errs++; $display("FAIL async_reset got d=%0d p=%0d t=%b r=%b exp 0", duty_out, period_out,
                       period_tick, ramping);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    wait_tick(ok);
    @(negedge clk);
    vectors++;
    if (!ok || duty_out !== W'(5)) begin
      errs++; $display("FAIL async_restart got %0d exp 5", duty_out);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_target_above();
    test_disable();
    test_shrink();
    test_random();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
